cia_serial_port: RTL and testbench

- Parametrised successor to the single-byte 6526-style serial data register in soc_6502.
- Adds configurable word width, TX/RX FIFOs, and selectable master (output) and slave (input) mode.
- Sits on the 6502 peripheral bus beside the GPIO/timer logic and drives the existing sp_in/sp_out/cnt_in/cnt_out pins.
- Timer A underflow pulses pace master-mode shifting; irq feeds the CPU interrupt OR.

---
 rtl/cia_pkg.sv | 34 +++
 rtl/sp_fifo.sv | 51 +++++
 rtl/cia_serial_port.sv | 216 +++++++++++++++++++++
 tb/tb_cia_serial_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared definitions for the CIA-style serial port: register map, STATUS/ICR/CTRL
// bit positions and the master shifter state encoding.
package cia_pkg;

  localparam logic [1:0] SP_DATA   = 2'd0;
  localparam logic [1:0] SP_STATUS = 2'd1;
  localparam logic [1:0] SP_CTRL   = 2'd2;
  localparam logic [1:0] SP_ICR    = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_OVR      = 5;
  localparam int ST_UNF      = 6;
  localparam int ST_DONE     = 7;

  localparam int ICR_DONE = 0;
  localparam int ICR_OVR  = 1;
  localparam int ICR_UNF  = 2;

  localparam int CTRL_MODE    = 0;
  localparam int CTRL_EN_DONE = 1;
  localparam int CTRL_EN_RX   = 2;
  localparam int CTRL_EN_ERR  = 3;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_SHIFT = 2'd1,
    M_GAP   = 2'd2
  } mstate_e;

endpackage

// File: rtl/sp_fifo.sv
// Show-ahead FIFO used for both the TX and RX word queues.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cia_serial_port.sv
// Parametrised 6526-style serial port: TX/RX FIFOs, tick-paced master shifter,
// synchronised slave receiver, sticky DONE/OVR/UNF flags and registered irq.
module cia_serial_port
  import cia_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              tick,
  input  logic              sp_in,
  output logic              sp_out,
  input  logic              cnt_in,
  output logic              cnt_out,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_W + 1);

  // ---------------- bus decode ----------------
  logic data_wr, ctrl_wr, icr_wr, data_rd, rd;
  logic [3:0] ctrl;
  logic mode, mode_chg;

  assign rd       = cs & ~we;
  assign data_wr  = cs & we & (addr == SP_DATA);
  assign ctrl_wr  = cs & we & (addr == SP_CTRL);
  assign icr_wr   = cs & we & (addr == SP_ICR);
  assign data_rd  = rd & (addr == SP_DATA);
  assign mode     = ctrl[CTRL_MODE];
  // A mode flip aborts whatever is in flight in the same cycle as the write.
  assign mode_chg = ctrl_wr & (din[CTRL_MODE] != mode);

  // ---------------- FIFOs ----------------
  logic [DATA_W-1:0] tx_rdata, rx_rdata, s_word;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]     tx_count, rx_count;
  logic              tx_pop, rx_pop, s_push;

  assign rx_pop = data_rd & ~rx_empty;

  sp_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(data_wr), .wdata(din), .pop(tx_pop), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sp_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(s_push), .wdata(s_word), .pop(rx_pop), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- master shifter ----------------
  mstate_e           state, state_n;
  logic [DATA_W-1:0] m_shreg, m_shreg_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic              cnt_out_n, sp_out_n, m_done;

  always_comb begin
    state_n   = state;
    m_shreg_n = m_shreg;
    bitcnt_n  = bitcnt;
    cnt_out_n = cnt_out;
    sp_out_n  = sp_out;
    tx_pop    = 1'b0;
    m_done    = 1'b0;
    if (mode_chg) begin
      state_n   = M_IDLE;
      bitcnt_n  = '0;
      cnt_out_n = 1'b1;
      sp_out_n  = 1'b1;
    end else begin
      case (state)
        M_IDLE: begin
          if (mode && !tx_empty) begin
            tx_pop    = 1'b1;
            m_shreg_n = tx_rdata;
            sp_out_n  = tx_rdata[DATA_W-1];
            bitcnt_n  = BW'(DATA_W);
            state_n   = M_SHIFT;
          end
        end
        M_SHIFT: begin
          if (bitcnt == '0 && cnt_out) begin
            m_done   = 1'b1;
            sp_out_n = 1'b1;
            state_n  = M_GAP;
          end else if (tick) begin
            cnt_out_n = ~cnt_out;
            if (cnt_out) begin
              // Falling edge: current MSB goes out, held through the next rise.
              sp_out_n  = m_shreg[DATA_W-1];
              m_shreg_n = m_shreg << 1;
            end else begin
              bitcnt_n = bitcnt - 1'b1;
            end
          end
        end
        M_GAP: begin
          if (tick) state_n = M_IDLE;
        end
        default: state_n = M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= M_IDLE;
      m_shreg <= '0;
      bitcnt  <= '0;
      cnt_out <= 1'b1;
      sp_out  <= 1'b1;
    end else begin
      state   <= state_n;
      m_shreg <= m_shreg_n;
      bitcnt  <= bitcnt_n;
      cnt_out <= cnt_out_n;
      sp_out  <= sp_out_n;
    end
  end

  // ---------------- slave receiver ----------------
  logic [SYNC_STAGES-1:0] cnt_sync, sp_sync;
  logic                   cnt_prev, cnt_s, sp_s, s_rise, s_last;
  logic [DATA_W-1:0]      s_shreg;
  logic [BW-1:0]          s_cnt;

  assign cnt_s  = cnt_sync[SYNC_STAGES-1];
  assign sp_s   = sp_sync[SYNC_STAGES-1];
  assign s_rise = cnt_s & ~cnt_prev & ~mode & ~mode_chg;
  assign s_word = {s_shreg[DATA_W-2:0], sp_s};
  assign s_last = s_rise & (s_cnt == BW'(DATA_W - 1));
  assign s_push = s_last;

  // Synchronisers reset high so a released bus with idle-high cnt_in sees no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_sync <= '1;
      sp_sync  <= '1;
      cnt_prev <= 1'b1;
      s_shreg  <= '0;
      s_cnt    <= '0;
    end else begin
      cnt_sync <= SYNC_STAGES'({cnt_sync, cnt_in});
      sp_sync  <= SYNC_STAGES'({sp_sync, sp_in});
      cnt_prev <= cnt_s;
      if (mode || mode_chg) begin
        s_cnt <= '0;
      end else if (s_rise) begin
        s_shreg <= s_word;
        s_cnt   <= s_last ? '0 : s_cnt + 1'b1;
      end
    end
  end

  // ---------------- flags, registers, irq ----------------
  logic done, ovr, unf, busy, ovr_set, unf_set;
  logic [DATA_W-1:0] status;
  logic [2*CW+2:0]   icr_view;

  assign busy    = (state != M_IDLE) | (s_cnt != '0);
  assign ovr_set = (data_wr & tx_full & ~tx_pop) | (s_push & rx_full & ~rx_pop);
  assign unf_set = data_rd & rx_empty;
  // ICR reads back pending flags with FIFO levels above them (truncated to bus width).
  assign icr_view = {rx_count, tx_count, unf, ovr, done};

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_BUSY]     = busy;
    status[ST_OVR]      = ovr;
    status[ST_UNF]      = unf;
    status[ST_DONE]     = done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= '0;
      done <= 1'b0;
      ovr  <= 1'b0;
      unf  <= 1'b0;
      irq  <= 1'b0;
      dout <= '0;
    end else begin
      if (ctrl_wr) ctrl <= din[3:0];
      // Set beats a same-cycle write-1-to-clear.
      done <= (done & ~(icr_wr & din[ICR_DONE])) | m_done | s_push;
      ovr  <= (ovr  & ~(icr_wr & din[ICR_OVR]))  | ovr_set;
      unf  <= (unf  & ~(icr_wr & din[ICR_UNF]))  | unf_set;
      irq  <= (done & ctrl[CTRL_EN_DONE]) | (~rx_empty & ctrl[CTRL_EN_RX]) |
              ((ovr | unf) & ctrl[CTRL_EN_ERR]);
      if (rd) begin
        case (addr)
          SP_DATA:   dout <= rx_empty ? '0 : rx_rdata;
          SP_STATUS: dout <= status;
          SP_CTRL:   dout <= DATA_W'(ctrl);
          default:   dout <= DATA_W'(icr_view);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cia_serial_port.sv
// Scoreboard bench: stimulus queues expected bus reads and serial words, monitors
// compare whenever dout is presented or a serial word completes on cnt_out rises.
module tb_cia_serial_port;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0, we = 1'b0, tick = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       sp_in = 1'b1, cnt_in = 1'b1;
  logic       sp_out, cnt_out, irq;

  int n_chk = 0;
  int n_fail = 0;
  int tick_no = 0;

  typedef struct { string name; logic [7:0] val; logic [7:0] mask; } rd_exp_t;
  typedef struct { logic [7:0] word; int first_tick; } tx_exp_t;
  rd_exp_t rd_q[$];
  tx_exp_t tx_q[$];

  cia_serial_port #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .tick(tick), .sp_in(sp_in), .sp_out(sp_out),
    .cnt_in(cnt_in), .cnt_out(cnt_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= cs && !we;

  logic       cnt_q = 1'b1;
  int         mon_bits = 0;
  int         mon_first = 0;
  logic [7:0] mon_word = 8'd0;

  always @(negedge clk) begin
    rd_exp_t re;
    tx_exp_t te;
    if (rd_seen) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 16'(dout), 16'hFFFF);
      else begin
        re = rd_q.pop_front();
        chk(re.name, 16'(dout & re.mask), 16'(re.val & re.mask));
      end
    end
    if (reset_n && cnt_out && !cnt_q) begin
      if (mon_bits == 0) mon_first = tick_no;
      mon_word = {mon_word[6:0], sp_out};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (tx_q.size() == 0) chk("tx_unexpected", 16'(mon_word), 16'hFFFF);
        else begin
          te = tx_q.pop_front();
          chk("tx_word", 16'(mon_word), 16'(te.word));
          chk("tx_first_tick", 16'(mon_first), 16'(te.first_tick));
        end
      end
    end
    cnt_q = cnt_out;
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input string name,
                        input logic [7:0] val, input logic [7:0] mask);
    rd_exp_t e;
    e.name = name; e.val = val; e.mask = mask;
    rd_q.push_back(e);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1;
    tick = 1'b1; tick_no++;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic expect_tx(input logic [7:0] w, input int first);
    tx_exp_t e;
    e.word = w; e.first_tick = first;
    tx_q.push_back(e);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      cnt_in = 1'b0; sp_in = w[i];
      repeat (4) @(posedge clk); #1;
      cnt_in = 1'b1;
      repeat (4) @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_dout", 16'(dout), 16'h0);
    chk("rst_sp_out", 16'(sp_out), 16'h1);
    chk("rst_cnt_out", 16'(cnt_out), 16'h1);
    chk("rst_irq", 16'(irq), 16'h0);
    bus_rd(2'd1, "rst_status", 8'h05, 8'hFF);

    // Master single word: A5 MSB first, done irq enabled
    bus_wr(2'd2, 8'h03);
    bus_wr(2'd0, 8'hA5);
    tick_no = 0;
    expect_tx(8'hA5, 2);
    repeat (3) @(posedge clk);
    ticks(15);
    pulse_tick();
    chk("m_irq_early", 16'(irq), 16'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("m_irq_done", 16'(irq), 16'h1);
    bus_rd(2'd1, "m_status_done_busy", 8'h90, 8'h90);
    ticks(1);
    bus_wr(2'd3, 8'h01);
    @(posedge clk); #1;
    chk("m_irq_cleared", 16'(irq), 16'h0);

    // Master burst: prefill TX in slave mode so the fifth write overflows
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd0, 8'h11);
    bus_wr(2'd0, 8'h22);
    bus_wr(2'd0, 8'h33);
    bus_wr(2'd0, 8'h44);
    bus_wr(2'd0, 8'h55);
    bus_rd(2'd1, "burst_full_ovr", 8'h22, 8'h23);
    bus_wr(2'd3, 8'h03);
    tick_no = 0;
    expect_tx(8'h11, 2);
    expect_tx(8'h22, 19);
    expect_tx(8'h33, 36);
    expect_tx(8'h44, 53);
    bus_wr(2'd2, 8'h01);
    repeat (2) @(posedge clk);
    ticks(68);
    bus_rd(2'd1, "burst_drained", 8'h01, 8'h33);
    bus_wr(2'd3, 8'h07);

    // Slave receive with rx_avail irq
    bus_wr(2'd2, 8'h04);
    @(posedge clk); #1;
    chk("s_irq_idle", 16'(irq), 16'h0);
    send_word(8'h3C);
    repeat (6) @(posedge clk); #1;
    chk("s_irq_rx", 16'(irq), 16'h1);
    bus_rd(2'd0, "s_data", 8'h3C, 8'hFF);
    bus_rd(2'd1, "s_rx_empty", 8'h04, 8'h0C);
    @(posedge clk); #1;
    chk("s_irq_drop", 16'(irq), 16'h0);
    chk("s_cnt_out_held", 16'(cnt_out), 16'h1);

    // Slave overrun: fifth word dropped, fifth read underflows
    bus_wr(2'd3, 8'h07);
    bus_wr(2'd2, 8'h08);
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    send_word(8'h04);
    send_word(8'h99);
    repeat (6) @(posedge clk); #1;
    bus_rd(2'd1, "ovr_status", 8'h28, 8'h2C);
    chk("ovr_irq", 16'(irq), 16'h1);
    bus_rd(2'd0, "ovr_rd1", 8'h01, 8'hFF);
    bus_rd(2'd0, "ovr_rd2", 8'h02, 8'hFF);
    bus_rd(2'd0, "ovr_rd3", 8'h03, 8'hFF);
    bus_rd(2'd0, "ovr_rd4", 8'h04, 8'hFF);
    bus_rd(2'd0, "unf_rd5", 8'h00, 8'hFF);
    bus_rd(2'd1, "unf_status", 8'h64, 8'h64);
    bus_wr(2'd3, 8'h07);

    // Abort mid-word by dropping back to slave mode
    bus_wr(2'd2, 8'h01);
    bus_wr(2'd0, 8'hFF);
    repeat (3) @(posedge clk);
    ticks(5);
    chk("abort_pre_cnt", 16'(cnt_out), 16'h0);
    bus_wr(2'd2, 8'h00);
    chk("abort_cnt_out", 16'(cnt_out), 16'h1);
    chk("abort_sp_out", 16'(sp_out), 16'h1);
    bus_rd(2'd1, "abort_status", 8'h00, 8'h90);
    ticks(2);
    chk("abort_cnt_stays", 16'(cnt_out), 16'h1);

    repeat (4) @(posedge clk);
    chk("tx_q_drained", 16'(tx_q.size()), 16'h0);
    chk("rd_q_drained", 16'(rd_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
